// File: rtl/tone_gen.sv
// tone_gen: prescaled square-wave tone generator; period changes take effect on half-cycle boundaries, period 0 silences.
// Optional TONE_GEN_VOLUME_EN adds a 4-bit volume port that PWM-gates the high phase.
module tone_gen #(
    parameter int PRESCALE = 64,
    parameter int PW       = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [PW-1:0] period_in,
`ifdef TONE_GEN_VOLUME_EN
    input  logic [3:0]    volume,
`endif
    output logic          audio_out,
    output logic          busy,
    output logic          cycle_pulse
);
    localparam int PCW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [PW-1:0] hcnt_q, hcnt_d;
    logic [PW-1:0] active_period_q, active_period_d;
    logic          square_q, square_d;
    logic          busy_q, busy_d;
    logic          cycle_pulse_q, cycle_pulse_d;
    logic          tick, boundary;

    always_comb begin
        tick            = pcnt_q == PCW'(PRESCALE - 1);
        pcnt_d          = tick ? '0 : pcnt_q + 1'b1;
        boundary        = state_q == RUN && tick && hcnt_q == active_period_q - 1'b1;
        state_d         = state_q;
        hcnt_d          = hcnt_q;
        active_period_d = active_period_q;
        square_d        = square_q;
        cycle_pulse_d   = 1'b0;
        if (state_q == IDLE) begin
            if (enable && period_in != '0) begin
                active_period_d = period_in;
                hcnt_d          = '0;
                square_d        = 1'b1;
                cycle_pulse_d   = 1'b1;
                state_d         = RUN;
            end
        end else if (boundary) begin
            hcnt_d = '0;
            if (!enable || period_in == '0) begin
                square_d        = 1'b0;
                state_d         = IDLE;
                active_period_d = '0;
            end else begin
                square_d        = ~square_q;
                active_period_d = period_in;
                cycle_pulse_d   = ~square_q;
            end
        end else if (tick) begin
            hcnt_d = hcnt_q + 1'b1;
        end
        busy_d = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pcnt_q          <= '0;
            hcnt_q          <= '0;
            active_period_q <= '0;
            square_q        <= 1'b0;
            busy_q          <= 1'b0;
            cycle_pulse_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pcnt_q          <= pcnt_d;
            hcnt_q          <= hcnt_d;
            active_period_q <= active_period_d;
            square_q        <= square_d;
            busy_q          <= busy_d;
            cycle_pulse_q   <= cycle_pulse_d;
        end
    end

`ifdef TONE_GEN_VOLUME_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;
    logic       audio_q, audio_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        audio_d   = square_d & (pwm_cnt_q < volume);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            audio_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            audio_q   <= audio_d;
        end
    end

    assign audio_out = audio_q;
`else
    assign audio_out = square_q;
`endif

    assign busy        = busy_q;
    assign cycle_pulse = cycle_pulse_q;
endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: checks tone_gen (PRESCALE=4) against a boundary-time model every cycle, plus hand-computed half-cycle lengths.
module tb_tone_gen;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [12:0] period_in = '0;
    logic        audio_out, busy, cycle_pulse;
`ifdef TONE_GEN_VOLUME_EN
    logic [3:0]  volume = 4'd15;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tone_gen #(.PRESCALE(P), .PW(13)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period_in   (period_in),
`ifdef TONE_GEN_VOLUME_EN
        .volume      (volume),
`endif
        .audio_out   (audio_out),
        .busy        (busy),
        .cycle_pulse (cycle_pulse)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: absolute edge index n since reset release; the next boundary is a precomputed edge number.
    longint n = 0;
    longint m_bound = 0;
    bit m_run = 0, m_sq = 0, m_pulse = 0, m_aud = 0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            n = 0; m_run = 0; m_sq = 0; m_pulse = 0; m_aud = 0;
        end else begin
            m_pulse = 0;
            if (!m_run) begin
                if (enable && period_in != 0) begin
                    m_run = 1; m_sq = 1; m_pulse = 1;
                    m_bound = n + 1 + (P - 1 - (n + 1) % P) + (longint'(period_in) - 1) * P;
                end
            end else if (n == m_bound) begin
                if (!enable || period_in == 0) begin
                    m_run = 0; m_sq = 0;
                end else begin
                    m_sq = !m_sq; m_pulse = m_sq;
                    m_bound = n + longint'(period_in) * P;
                end
            end
`ifdef TONE_GEN_VOLUME_EN
            m_aud = m_sq && (n % 16 < longint'(volume));
`else
            m_aud = m_sq;
`endif
            n++;
        end
        #1;
        check("model_audio", audio_out, m_aud);
        check("model_busy", busy, m_run);
        check("model_pulse", cycle_pulse, m_pulse);
    end

    task automatic wait_change(output int len);
        logic cur;
        cur = audio_out;
        len = 0;
        while (audio_out == cur && len < 2000) begin
            @(negedge clk);
            len++;
        end
        if (len >= 2000) check("wait_change_timeout", len, -1);
    endtask

    task automatic pulse_gap(output int len);
        int w;
        w = 0;
        while (!cycle_pulse && w < 200) begin @(negedge clk); w++; end
        len = 0;
        do begin @(negedge clk); len++; end while (!cycle_pulse && len < 200);
    endtask

    int len;

    initial begin
        rst_n = 1'b0; enable = 1'b1; period_in = 13'd500;
        repeat (3) @(negedge clk);
        check("reset_audio", audio_out, 0);
        check("reset_busy", busy, 0);
        check("reset_pulse", cycle_pulse, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("start_latency_audio", audio_out, 1);
        check("start_latency_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_audio", audio_out, 0);
        check("async_reset_busy", busy, 0);
        period_in = 13'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_latency", audio_out, 1);
        @(negedge clk);
`ifndef TONE_GEN_VOLUME_EN
        wait_change(len);
        wait_change(len); check("p3_low_len", len, 12);
        wait_change(len); check("p3_high_len", len, 12);
        pulse_gap(len);   check("p3_pulse_gap", len, 24);
        repeat (2) @(negedge clk);
        period_in = 13'd5;
        wait_change(len); check("p3to5_current_half", len, 10);
        wait_change(len); check("p5_low_len", len, 20);
        wait_change(len); check("p5_high_len", len, 20);
        wait_change(len); check("p5_low_len2", len, 20);
        period_in = 13'd0;
        wait_change(len); check("stop_p0_high_len", len, 20);
        check("stop_p0_busy", busy, 0);
        check("stop_p0_audio", audio_out, 0);
        repeat (10) @(negedge clk);
        check("idle_p0_busy", busy, 0);
        period_in = 13'd2;
        @(negedge clk);
        check("restart_p2_audio", audio_out, 1);
        wait_change(len);
        wait_change(len); check("p2_low_len", len, 8);
        enable = 1'b0;
        wait_change(len); check("stop_en_high_len", len, 8);
        check("stop_en_busy", busy, 0);
        enable = 1'b1; period_in = 13'd1;
        @(negedge clk);
        wait_change(len);
        wait_change(len); check("p1_low_len", len, 4);
        wait_change(len); check("p1_high_len", len, 4);
        wait_change(len); check("p1_low_len2", len, 4);
        enable = 1'b0;
        wait_change(len); check("p1_stop_len", len, 4);
        check("p1_stop_busy", busy, 0);
`else
        rst_n = 1'b0; period_in = 13'd10; volume = 4'd4;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        volume = 4'd0;
        repeat (100) @(negedge clk);
        check("vol0_busy", busy, 1);
        check("vol0_audio", audio_out, 0);
        enable = 1'b0;
`endif
        repeat (50) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream consumer of the note-to-period lookup stage.
- Takes the registered 13-bit half-period word (units of prescaled ticks) and produces a glitch-free square-wave audio output for the speaker/PWM pin.
- Period changes are applied only on half-cycle boundaries. Period 0 means silence.
- At 50 MHz with PRESCALE=64, the tick rate is 781.25 kHz, which matches the lookup table (5971 gives C2 at ~65.4 Hz; 746 gives C5 at ~523.6 Hz).

Parameters:
- PRESCALE, 64: system clocks per tick; legal range ≥1.
- PW, 13: width of the period word.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  tone gate; 0 requests stop.
- period_in  in  PW  half-period in ticks; 0 means silence.
- audio_out  out  1  square wave (registered).
- busy  out  1  high while in RUN.
- cycle_pulse  out  1  one-clk pulse on each rising edge of audio_out.
- volume  in  4  present only with TONE_GEN_VOLUME_EN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pcnt, hcnt, active_period=0; audio_out, busy, cycle_pulse=0.
- Reset mid-tone kills the output immediately. There is no ramp-down.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and is free-running from reset release.
  - tick=1 for the single clk where pcnt==PRESCALE-1, then pcnt wraps to 0.
  - PRESCALE=1 means tick every clk.
- IDLE:
  - audio_out=0, hcnt=0.
  - On any clk (not tick-aligned) with enable=1 and period_in≠0: active_period<=period_in, hcnt<=0, audio_out<=1, cycle_pulse<=1, state<=RUN.
  - Latency: 1 clk from input to audio_out high.
- RUN:
  - On tick: if hcnt==active_period-1, it is a boundary; otherwise hcnt<=hcnt+1.
  - Non-tick clks hold all state.
- Boundary handling:
  - hcnt<=0.
  - If enable=0 or period_in==0: audio_out<=0, state<=IDLE, active_period<=0.
  - Otherwise: audio_out<=~audio_out, active_period<=period_in. cycle_pulse<=1 if this is a 0→1 transition.
- period_in changes between boundaries are ignored. The value present on the boundary clk wins.
- The first half-cycle after a start may be up to PRESCALE-1 clks short (prescaler not realigned). This is accepted.
- active_period==1: toggles every tick.
- Max period 8191: hcnt is PW bits and never overflows, since compare is against active_period-1.
- cycle_pulse is high for exactly one clk and is otherwise 0.
- busy = (state==RUN), registered alongside state.
- Stop is always on a boundary, so no runt pulses except at reset.

Optional Feature:
- TONE_GEN_VOLUME_EN defined:
  - volume[3:0] port exists.
  - 4-bit free-running pwm_cnt (per clk, reset 0).
  - audio_out = square & (pwm_cnt < volume), registered.
  - volume=0 gives silence; volume=15 gives 15/16 duty during the high phase.
  - busy and cycle_pulse follow the underlying square, not the gated output.
- Undefined: no volume port; audio_out = square.

Test Plan:
- Reset: rst_n=0 with enable=1, period_in=500 → audio_out=0, busy=0, cycle_pulse=0. Release → toggling begins 1 clk later.
- PRESCALE=4, period_in=3, enable=1 → audio_out high 12 clks then low 12 clks (after the first possibly-short half); cycle_pulse one clk every 24 clks; busy=1.
- Change period_in 3→5 mid-half-cycle → current half stays 12 clks; following halves are 20 clks.
- period_in→0 while high → output stays high until the next boundary, then audio_out=0 and busy=0. An enable=0 drop behaves identically.
- Reset asserted mid-RUN with audio_out=1 → audio_out=0 asynchronously. After release with inputs unchanged, restart in 1 clk.
- TONE_GEN_VOLUME_EN, volume=4, PRESCALE=64, period_in=10 → during the high phase, audio_out is high 4 of every 16 clks. volume=0 → audio_out constantly 0 while busy=1.
